// File: rtl/eth_pkg.sv
// eth_pkg: shared types and constants for the MII receive path.
// Holds the receive FSM state type, the fixed preamble words written ahead of
// every frame, the frame RAM address width and the preamble/SFD nibble codes.
package eth_pkg;
  typedef enum logic [2:0] {IDLE, HUNT, CAPTURE, FLUSH, DONE, LOCK, DISCARD} rx_state_t;
  localparam int RAM_ADDR_W = 9;
  localparam logic [31:0] PREAMBLE_WORD0 = 32'h5555_5555;
  localparam logic [31:0] PREAMBLE_WORD1 = 32'h5D55_5555;
  localparam logic [3:0] NIB_SFD = 4'hD;
  localparam logic [3:0] NIB_PRE = 4'h5;
endpackage

// File: rtl/mii_nibble_packer.sv
// mii_nibble_packer: packs MII nibbles into 32-bit words, byte-swapped per byte.
// Ports: clk, rst_n (async, active-low); i_clr restarts packing; i_shift accepts
// i_nib; o_nib_cnt is the count of nibbles in the current word; o_word is the
// current word including i_nib (valid for the 8th nibble); o_flush is the
// partial word with unfilled nibble positions zero.
module mii_nibble_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_shift,
  input  logic [3:0]  i_nib,
  output logic [2:0]  o_nib_cnt,
  output logic [31:0] o_word,
  output logic [31:0] o_flush
);
  logic [31:0] r_word;
  logic [2:0]  r_cnt;
  logic [4:0]  w_off;
  // Even nibbles land in the high half of their byte, odd ones in the low half.
  assign w_off = {r_cnt[2:1], ~r_cnt[0], 2'b00};
  // Starting a new word discards the previous one, which keeps o_flush zero-padded.
  assign o_word = (r_cnt == 3'd0 ? 32'd0 : r_word) | ({28'd0, i_nib} << w_off);
  assign o_nib_cnt = r_cnt;
  assign o_flush = r_word;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word <= '0;
      r_cnt  <= '0;
    end else if (i_clr) begin
      r_word <= '0;
      r_cnt  <= '0;
    end else if (i_shift) begin
      r_word <= o_word;
      r_cnt  <= r_cnt + 3'd1;
    end
  end
endmodule

// File: rtl/mii_rx_capture.sv
// mii_rx_capture: MII receive front end; qualifies preamble/SFD and stores frames in RAM.
// Ports: clk, rst_n (async, active-low); mii_rxd/mii_rx_dv/mii_rx_er from the PHY;
// wr_data/wr_addr/wr_ena drive the frame RAM; newpacket pulses for a stored frame
// of frame_len words; drop_count counts dropped frames (saturating); busy is high
// outside IDLE.
module mii_rx_capture
  import eth_pkg::*;
#(
  parameter int LOCK_CYCLES      = 2048,
  parameter int MIN_PREAMBLE_NIB = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            mii_rxd,
  input  logic                  mii_rx_dv,
  input  logic                  mii_rx_er,
  output logic [31:0]           wr_data,
  output logic [RAM_ADDR_W-1:0] wr_addr,
  output logic                  wr_ena,
  output logic                  newpacket,
  output logic [RAM_ADDR_W:0]   frame_len,
  output logic [7:0]            drop_count,
  output logic                  busy
);
  localparam int LW = $clog2(LOCK_CYCLES + 1);
  rx_state_t             r_state, w_next;
  logic                  r_dv_prev, r_pend1, r_wr_ena, r_newpacket, r_busy;
  logic [3:0]            r_five, w_five;
  logic [RAM_ADDR_W:0]   r_word_addr, r_frame_len;
  logic [LW-1:0]         r_lock;
  logic [7:0]            r_drop_count;
  logic [31:0]           r_wr_data, w_data, w_word, w_flush;
  logic [RAM_ADDR_W-1:0] r_wr_addr, w_addr;
  logic [2:0]            w_nib_cnt;
  logic                  w_rise, w_hunt, w_wr, w_inc, w_drop, w_shift, w_clr;
  mii_nibble_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_clr),
    .i_shift   (w_shift),
    .i_nib     (mii_rxd),
    .o_nib_cnt (w_nib_cnt),
    .o_word    (w_word),
    .o_flush   (w_flush)
  );
  assign w_rise = mii_rx_dv & ~r_dv_prev;
  // The nibble that arms IDLE is already treated as the first HUNT nibble.
  assign w_hunt = (r_state == HUNT) | ((r_state == IDLE) & w_rise);
  assign w_five = (r_state == HUNT) ? r_five : 4'd0;
  always_comb begin
    w_next  = r_state;
    w_wr    = 1'b0;
    w_addr  = r_word_addr[RAM_ADDR_W-1:0];
    w_data  = w_word;
    w_inc   = 1'b0;
    w_drop  = 1'b0;
    w_shift = 1'b0;
    w_clr   = 1'b0;
    if (w_hunt) begin
      if (!mii_rx_dv) begin
        w_next = IDLE;
        w_drop = 1'b1;
      end else if (mii_rx_er || !(mii_rxd == NIB_PRE ||
                   (mii_rxd == NIB_SFD && w_five >= 4'(MIN_PREAMBLE_NIB)))) begin
        w_next = DISCARD;
        w_drop = 1'b1;
      end else if (mii_rxd == NIB_SFD) begin
        w_next = CAPTURE;
        w_wr   = 1'b1;
        w_addr = '0;
        w_data = PREAMBLE_WORD0;
        w_clr  = 1'b1;
      end else begin
        w_next = HUNT;
      end
    end else begin
      case (r_state)
        CAPTURE: begin
          // The second preamble word goes out on the first CAPTURE edge, which
          // can never complete a data word, so the two writes never collide.
          w_wr   = r_pend1 & ~(mii_rx_dv & mii_rx_er);
          w_addr = RAM_ADDR_W'(1);
          w_data = PREAMBLE_WORD1;
          if (!mii_rx_dv) begin
            w_next = (w_nib_cnt == 3'd0) ? DONE : (r_word_addr[RAM_ADDR_W] ? DISCARD : FLUSH);
            w_drop = (w_nib_cnt != 3'd0) & r_word_addr[RAM_ADDR_W];
          end else if (mii_rx_er) begin
            w_next = DISCARD;
            w_drop = 1'b1;
          end else begin
            w_shift = 1'b1;
            if (w_nib_cnt == 3'd7) begin
              if (r_word_addr[RAM_ADDR_W]) begin
                w_next = DISCARD;
                w_drop = 1'b1;
              end else begin
                w_wr   = 1'b1;
                w_addr = r_word_addr[RAM_ADDR_W-1:0];
                w_data = w_word;
                w_inc  = 1'b1;
              end
            end
          end
        end
        FLUSH: begin
          w_wr   = 1'b1;
          w_data = w_flush;
          w_inc  = 1'b1;
          w_next = DONE;
        end
        DONE:    w_next = LOCK;
        LOCK: begin
          w_drop = w_rise;
          w_next = (r_lock == '0 && !mii_rx_dv) ? IDLE : LOCK;
        end
        DISCARD: w_next = mii_rx_dv ? DISCARD : IDLE;
        default: w_next = r_state;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_dv_prev    <= 1'b1;
      r_pend1      <= 1'b0;
      r_five       <= '0;
      r_word_addr  <= '0;
      r_lock       <= '0;
      r_wr_data    <= '0;
      r_wr_addr    <= '0;
      r_wr_ena     <= 1'b0;
      r_newpacket  <= 1'b0;
      r_frame_len  <= '0;
      r_drop_count <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_dv_prev   <= mii_rx_dv;
      r_pend1     <= w_clr;
      r_five      <= (w_next == HUNT) ? w_five + 4'(w_five != 4'hF) : 4'd0;
      r_word_addr <= w_clr ? (RAM_ADDR_W+1)'(2) : r_word_addr + (RAM_ADDR_W+1)'(w_inc);
      r_lock      <= (r_state == DONE) ? LW'(LOCK_CYCLES - 1) : r_lock - LW'(r_lock != '0);
      r_wr_ena    <= w_wr;
      if (w_wr) begin
        r_wr_addr <= w_addr;
        r_wr_data <= w_data;
      end
      r_newpacket <= (r_state == DONE);
      if (r_state == DONE) r_frame_len <= r_word_addr;
      if (w_drop && r_drop_count != 8'hFF) r_drop_count <= r_drop_count + 8'd1;
      r_busy      <= (w_next != IDLE);
    end
  end
  assign wr_data    = r_wr_data;
  assign wr_addr    = r_wr_addr;
  assign wr_ena     = r_wr_ena;
  assign newpacket  = r_newpacket;
  assign frame_len  = r_frame_len;
  assign drop_count = r_drop_count;
  assign busy       = r_busy;
endmodule

// File: doc/mii_rx_capture.md
# mii_rx_capture

Receive-side front end that sits directly upstream of the Ethernet frame parser. It samples the PHY's 4-bit MII receive bus, qualifies the preamble/SFD and packs nibbles into 32-bit words in the nibble-swapped byte format the parser expects. It writes each frame into the shared frame RAM starting at address 0 and pulses `newpacket` when a complete, error-free frame is stored.

## Interface
- `LOCK_CYCLES`, 2048: cycles after `newpacket` during which new frames are dropped, so the parser can drain the RAM.
- `MIN_PREAMBLE_NIB`, 6: minimum count of consecutive 0x5 nibbles required before the SFD nibble 0xD.
- `clk`  in  1  PHY receive clock (25 MHz); the only clock.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `mii_rxd`  in  4  receive nibble, sampled on posedge `clk`.
- `mii_rx_dv`  in  1  receive data valid.
- `mii_rx_er`  in  1  receive error.
- `wr_data`  out  32  frame RAM write data.
- `wr_addr`  out  9  frame RAM write address.
- `wr_ena`  out  1  frame RAM write enable.
- `newpacket`  out  1  one-cycle pulse: frame stored, RAM valid.
- `frame_len`  out  10  number of words written for the last good frame, including the 2 preamble words.
- `drop_count`  out  8  saturating count of dropped frames.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, HUNT, CAPTURE, FLUSH, DONE, LOCK, DISCARD.
- Byte/nibble packing: nibble k of a word (k = 0..7, arrival order) lands in byte b = k/2.
  - Even k goes to bits [8b+7:8b+4].
  - Odd k goes to bits [8b+3:8b].
- IDLE: arms only on a rising edge of `mii_rx_dv` (the previous-cycle sample must be 0), then goes to HUNT with `five_cnt` = 0. The sampled nibble is processed as the first HUNT nibble.
- HUNT:
  - Nibble 0x5: `five_cnt`++ (saturates at 15).
  - Nibble 0xD with `five_cnt` ≥ `MIN_PREAMBLE_NIB`: write addr 0 = 32'h5555_5555. On the next edge write addr 1 = 32'h5D55_5555. Go to CAPTURE.
  - Any other nibble, `mii_rx_er`=1, or `mii_rx_dv` falling: `drop_count`++ and go to DISCARD, or to IDLE if `mii_rx_dv`=0.
- CAPTURE: each cycle with `mii_rx_dv`=1, shift in the nibble and increment `nib_cnt` (3 bits).
  - When the 8th nibble is sampled, write the word at `word_addr` (starts at 2), then `word_addr`++.
  - `mii_rx_er`=1: go to DISCARD, `drop_count`++.
  - A write needed at `word_addr` > 511: go to DISCARD, `drop_count`++. RAM addresses 0..511 never wrap.
  - `mii_rx_dv`=0 with `nib_cnt`=0: go to DONE.
  - `mii_rx_dv`=0 with `nib_cnt`≠0: go to FLUSH.
- FLUSH: write the partial word with unfilled nibble positions set to 0, then go to DONE.
- DONE: pulse `newpacket`, latch `frame_len` = `word_addr`, load the lock counter with `LOCK_CYCLES`-1, go to LOCK.
- LOCK:
  - The counter decrements every cycle.
  - A rising edge of `mii_rx_dv` inside LOCK: `drop_count`++ once per frame; nothing is written.
  - Exit to IDLE when the counter is 0 and `mii_rx_dv`=0.
- DISCARD: no writes, no `newpacket`. Go to IDLE when `mii_rx_dv`=0.
- `drop_count` saturates at 255.

## Timing
- All outputs are registered.
- Reset values: `wr_data`=0, `wr_addr`=0, `wr_ena`=0, `newpacket`=0, `frame_len`=0, `drop_count`=0, `busy`=0. State is IDLE and the previous `mii_rx_dv` register is 1, so a frame already in progress at reset release is ignored.
- `wr_ena` is high for exactly one cycle per word. It is visible on the cycle after the edge that samples the completing nibble (or the SFD, or the first CAPTURE nibble for addr 1).
- The addr 1 write and the first data word can never collide: they are at least 7 cycles apart.
- `newpacket` rises 2 cycles after the edge that samples `mii_rx_dv`=0 when `nib_cnt`=0, and 3 cycles after it when `nib_cnt`≠0.
- Reset asserted mid-frame: outputs clear immediately (asynchronous). RAM contents are undefined and no `newpacket` is issued.

## Structure
- Shared `eth_pkg`:
  - `rx_state_t` enum.
  - `PREAMBLE_WORD0` = 32'h5555_5555, `PREAMBLE_WORD1` = 32'h5D55_5555.
  - `RAM_ADDR_W` = 9, `NIB_SFD` = 4'hD, `NIB_PRE` = 4'h5.
- Sub-module `mii_nibble_packer`: nibble shift register with `nib_cnt`, swapped-byte placement and a zero-padded flush output.

## Test plan
- Preamble of 15×0x5, SFD 0xD, then 64 bytes with no error: writes at addr 0 (5555_5555), addr 1 (5D55_5555) and addrs 2..17; `frame_len`=18; one `newpacket` pulse.
- Byte 0xA1 at the first data position: `wr_data`[7:0] = 0x1A at addr 2.
- 65-byte frame (130 nibbles, partial final word): the FLUSH write at addr 18 has `wr_data`[31:8]=0; `frame_len`=19.
- `mii_rx_er` pulsed at nibble 40: no `newpacket`, `drop_count`=1, and no writes after the error.
- Preamble of only 4×0x5 before 0xD: frame dropped, `drop_count`=1, no writes.
- Second frame starting 100 cycles after `newpacket`: no writes, `drop_count`++. A third frame after `LOCK_CYCLES` is captured normally.
- 2100-byte frame: stops at addr 511, then DISCARD, `drop_count`++, no `newpacket`.
